// File: rtl/mem_access_unit.sv
// Load/store unit: one single-word request/acknowledge transaction per access.
// Builds byte strobes and lane-replicated store data, and extracts and extends
// load data. Every output comes straight from a flop.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    // The counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        in_load, in_store, f3_ok, misaligned, access_ok;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        timed_out;

    // Legality of the access presented on the inputs (only used in IDLE).
    always_comb begin
        in_load    = (opcode == OP_LOAD);
        in_store   = (opcode == OP_STORE);
        f3_ok      = 1'b0;
        if (in_load)
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        else if (in_store)
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        access_ok  = (in_load || in_store) && f3_ok && !misaligned;
    end

    // Pick the addressed byte/half of the returned word and extend it.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
        timed_out = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));
    end

    // Next-state and next-output logic for IDLE -> BUS -> RESP -> IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    is_load_d = in_load;
                    funct3_d  = funct3;
                    off_d     = addr[1:0];
                    if (!access_ok) begin
                        // Rejected before the bus is touched.
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = BUS;
                        busy_d     = 1'b1;
                        mem_req_d  = 1'b1;
                        cnt_d      = '0;
                        mem_addr_d = {addr[31:2], 2'b00};
                        mem_we_d   = in_store;
                        if (in_load) begin
                            mem_wstrb_d = 4'b0000;
                            mem_wdata_d = 32'd0;
                        end else begin
                            case (funct3[1:0])
                                2'b00: begin
                                    mem_wstrb_d = 4'b0001 << addr[1:0];
                                    mem_wdata_d = {4{wdata[7:0]}};
                                end
                                2'b01: begin
                                    mem_wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
                                    mem_wdata_d = {2{wdata[15:0]}};
                                end
                                default: begin
                                    mem_wstrb_d = 4'b1111;
                                    mem_wdata_d = wdata;
                                end
                            endcase
                        end
                    end
                end
            end
            BUS: begin
                if (mem_ack) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = is_load_q ? ld_ext : 32'd0;
                end else if (timed_out) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    mem_req_d = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            default: begin
                // RESP: the done pulse is on the outputs now; start is ignored.
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any pending access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wstrb_q <= 4'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected completions are queued when an
// access is launched and compared when done appears.
module tb_mem_access_unit;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [31:0] IDLE_BUS = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = IDLE_BUS;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_rdata", rdata, e.rd);
                chk("done_err", {31'd0, err}, {31'd0, e.er});
                chk("done_cycle", cyc, e.cyc);
                chk("done_busy", {31'd0, busy}, 32'd0);
                $display("txn done cyc=%0d rdata=%h err=%0b", cyc, rdata, err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er,
                          input int done_off);
        sb.push_back('{rd: exp_rd, er: exp_er, cyc: cyc + done_off});
        opcode = op; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Full bus access: ack arrives 'dly' cycles after the first request cycle.
    task automatic bus_txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                           input int dly, input logic [31:0] exp_rd, input logic exp_we,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wd);
        launch(op, f3, a, wd, exp_rd, 1'b0, 2 + dly);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, exp_we});
        chk({tag, "_strb"}, {28'd0, mem_wstrb}, {28'd0, exp_strb});
        if (exp_we) chk({tag, "_wdata"}, mem_wdata, exp_wd);
        repeat (dly) tick();
        mem_ack = 1'b1; mem_rdata = word;
        tick();
        mem_ack = 1'b0; mem_rdata = IDLE_BUS;
        chk({tag, "_req_off"}, {31'd0, mem_req}, 32'd0);
        tick();
    endtask

    initial begin
        int n;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_strb", {28'd0, mem_wstrb}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        bus_txn("lb", LD, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 2, 32'hFFFF_FF80, 1'b0, 4'b0000, 32'd0);
        bus_txn("lhu", LD, 3'b101, 32'h0000_1002, 32'd0, 32'h8001_0000, 1, 32'h0000_8001, 1'b0, 4'b0000, 32'd0);
        bus_txn("lh", LD, 3'b001, 32'h0000_1002, 32'd0, 32'h8001_0000, 0, 32'hFFFF_8001, 1'b0, 4'b0000, 32'd0);
        bus_txn("lbu", LD, 3'b100, 32'h0000_1001, 32'd0, 32'h1234_5678, 1, 32'h0000_0056, 1'b0, 4'b0000, 32'd0);
        bus_txn("lw", LD, 3'b010, 32'h0000_4000, 32'd0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'd0);
        bus_txn("sh", ST, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 32'h0, 0, 32'd0, 1'b1, 4'b1100, 32'hBEEF_BEEF);
        bus_txn("sb", ST, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h0, 1, 32'd0, 1'b1, 4'b0010, 32'hA5A5_A5A5);
        bus_txn("sw", ST, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 32'h0, 2, 32'd0, 1'b1, 4'b1111, 32'hCAFE_F00D);

        // Error path: rejected in IDLE, done/err on the next cycle, bus untouched.
        launch(LD, 3'b010, 32'h0000_1001, 32'd0, 32'd0, 1'b1, 1);
        chk("lw_mis_req", {31'd0, mem_req}, 32'd0);
        tick();
        launch(LD, 3'b011, 32'h0000_1000, 32'd0, 32'd0, 1'b1, 1);
        chk("f3_011_req", {31'd0, mem_req}, 32'd0);
        tick();
        launch(7'b0110011, 3'b000, 32'h0000_1000, 32'd0, 32'd0, 1'b1, 1);
        chk("bad_op_req", {31'd0, mem_req}, 32'd0);
        tick();
        launch(ST, 3'b100, 32'h0000_1000, 32'd0, 32'd0, 1'b1, 1);
        chk("st_f3_req", {31'd0, mem_req}, 32'd0);
        tick();

        // Timeout: request held exactly 16 cycles, then done with err.
        launch(ST, 3'b010, 32'h0000_5000, 32'h1111_2222, 32'd0, 1'b1, 17);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) n++;
            if (done) break;
        end
        chk("timeout_req_cycles", n, 32'd16);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        mem_ack = 1'b0; mem_rdata = IDLE_BUS;
        chk("late_ack_req", {31'd0, mem_req}, 32'd0);
        chk("late_ack_busy", {31'd0, busy}, 32'd0);
        tick();

        // Start pulses while busy and during the done cycle are ignored.
        launch(LD, 3'b010, 32'h0000_6000, 32'd0, 32'h0BAD_F00D, 1'b0, 5);
        start = 1'b1; tick(); start = 1'b0; tick();
        start = 1'b1; tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0; mem_rdata = IDLE_BUS;
        chk("busy_start_done", {31'd0, done}, 32'd1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("no_second_req", {31'd0, mem_req}, 32'd0);
            tick();
        end

        // Reset mid-BUS drops the request with no done pulse.
        launch(LD, 3'b010, 32'h0000_7000, 32'd0, 32'd0, 1'b0, 99);
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        start = 1'b1; tick(); start = 1'b0; tick();
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_req", {31'd0, mem_req}, 32'd0);
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
